// File: rtl/addern_seq_pkg.sv
// Shared definitions for the sequential multi-precision adder/subtractor.
package addern_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N = 32;
    localparam int DEF_K = 8;

    // Index register width for a given chunk count; never narrower than one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

    // One-bit full adder; returns {carry_out, sum}.
    function automatic logic [1:0] fulladd(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/addern_seq_if.sv
// Operand/result handshake bundle for addern_seq.
interface addern_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic         sub;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic         carryin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] S;
    logic         carryout;
    logic         overflow;

    modport master (
        output in_valid, sub, X, Y, carryin, out_ready,
        input  in_ready, out_valid, S, carryout, overflow
    );

    modport slave (
        input  in_valid, sub, X, Y, carryin, out_ready,
        output in_ready, out_valid, S, carryout, overflow
    );
endinterface

// File: rtl/chunk_adder.sv
// K-bit ripple-carry adder built from a chain of full adders; purely combinational.
module chunk_adder
    import addern_seq_pkg::*;
#(
    parameter int K = 8
) (
    input  logic         carryin,
    input  logic [K-1:0] X,
    input  logic [K-1:0] Y,
    output logic [K-1:0] S,
    output logic         carryout
);

    logic [K:0] cc;

    // Ripple the carry from bit 0 upward.
    always_comb begin
        cc    = '0;
        S     = '0;
        cc[0] = carryin;
        for (int i = 0; i < K; i++) begin
            {cc[i+1], S[i]} = fulladd(X[i], Y[i], cc[i]);
        end
    end

    assign carryout = cc[K];

endmodule

// File: rtl/addern_seq.sv
// Sequential N-bit add/subtract: one K-bit chunk per cycle, carry held in a register.
module addern_seq
    import addern_seq_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) (
    input  logic         clk,
    input  logic         resetn,
    addern_seq_if.slave  bus,
    output logic         busy
);

    localparam int NCHUNK = N / K;
    localparam int IW     = idx_width(NCHUNK);

    if ((N % K) != 0) begin : g_bad_width
        $error("addern_seq: N must be a multiple of K");
    end

    state_t         state;
    logic [N-1:0]   xr;
    logic [N-1:0]   yr;
    logic [N-1:0]   s_acc;
    logic [N-1:0]   s_r;
    logic           c;
    logic [IW-1:0]  idx;
    logic           carryout_r;
    logic           overflow_r;
    logic           out_valid_r;
    logic           xsign;
    logic           ysign;

    logic [K-1:0]   chunk;
    logic           chunk_co;
    logic [N+K-1:0] s_cat;
    logic [N-1:0]   s_next;
    logic           last;

    chunk_adder #(.K(K)) u_chunk (
        .carryin  (c),
        .X        (xr[K-1:0]),
        .Y        (yr[K-1:0]),
        .S        (chunk),
        .carryout (chunk_co)
    );

    // New chunk enters at the top so the LSB chunk ends up at the bottom after NCHUNK shifts.
    assign s_cat  = {chunk, s_acc};
    assign s_next = s_cat[N+K-1:K];
    assign last   = (idx == IW'(NCHUNK - 1));

    // Controller: operand capture, chunk sequencing, result hold until consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            xr          <= '0;
            yr          <= '0;
            s_acc       <= '0;
            s_r         <= '0;
            c           <= 1'b0;
            idx         <= '0;
            carryout_r  <= 1'b0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            xsign       <= 1'b0;
            ysign       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        xr    <= bus.X;
                        yr    <= bus.sub ? ~bus.Y : bus.Y;
                        c     <= bus.carryin ^ bus.sub;
                        idx   <= '0;
                        s_acc <= '0;
                        xsign <= bus.X[N-1];
                        ysign <= bus.Y[N-1] ^ bus.sub;
                        state <= RUN;
                    end
                end
                RUN: begin
                    xr    <= xr >> K;
                    yr    <= yr >> K;
                    c     <= chunk_co;
                    s_acc <= s_next;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        // Result registers only change here, so they stay stable through IDLE and RUN.
                        s_r         <= s_next;
                        carryout_r  <= chunk_co;
                        overflow_r  <= (xsign == ysign) && (s_next[N-1] != xsign);
                        out_valid_r <= 1'b1;
                        idx         <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.S         = s_r;
    assign bus.carryout  = carryout_r;
    assign bus.overflow  = overflow_r;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_addern_seq.sv
// Scoreboard bench for addern_seq: directed vectors on K=8, model sweep on K=32 and K=4.
module tb_addern_seq;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t q8[$];
    exp_t q32[$];
    exp_t q4[$];

    logic busy8, busy32, busy4;
    logic pv8 = 1'b0, pv32 = 1'b0, pv4 = 1'b0;

    addern_seq_if #(.N(32)) b8 ();
    addern_seq_if #(.N(32)) b32 ();
    addern_seq_if #(.N(32)) b4 ();

    addern_seq #(.N(32), .K(8))  dut8  (.clk(clk), .resetn(resetn), .bus(b8),  .busy(busy8));
    addern_seq #(.N(32), .K(32)) dut32 (.clk(clk), .resetn(resetn), .bus(b32), .busy(busy32));
    addern_seq #(.N(32), .K(4))  dut4  (.clk(clk), .resetn(resetn), .bus(b4),  .busy(busy4));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Monitors: compare each result when out_valid rises, including its latency.
    always @(negedge clk) begin
        exp_t e;
        if (b8.out_valid && !pv8) begin
            if (q8.size() == 0) bound_fail("k8_unexpected_output");
            else begin
                e = q8.pop_front();
                check("k8_S", b8.S, e.s);
                check("k8_carryout", {31'd0, b8.carryout}, {31'd0, e.co});
                check("k8_overflow", {31'd0, b8.overflow}, {31'd0, e.ov});
                check("k8_latency", cyc - e.acc, 32'd4);
            end
        end
        pv8 = b8.out_valid;
    end

    always @(negedge clk) begin
        exp_t e;
        if (b32.out_valid && !pv32) begin
            if (q32.size() == 0) bound_fail("k32_unexpected_output");
            else begin
                e = q32.pop_front();
                check("k32_S", b32.S, e.s);
                check("k32_carryout", {31'd0, b32.carryout}, {31'd0, e.co});
                check("k32_overflow", {31'd0, b32.overflow}, {31'd0, e.ov});
                check("k32_latency", cyc - e.acc, 32'd1);
            end
        end
        pv32 = b32.out_valid;
    end

    always @(negedge clk) begin
        exp_t e;
        if (b4.out_valid && !pv4) begin
            if (q4.size() == 0) bound_fail("k4_unexpected_output");
            else begin
                e = q4.pop_front();
                check("k4_S", b4.S, e.s);
                check("k4_carryout", {31'd0, b4.carryout}, {31'd0, e.co});
                check("k4_overflow", {31'd0, b4.overflow}, {31'd0, e.ov});
                check("k4_latency", cyc - e.acc, 32'd8);
            end
        end
        pv4 = b4.out_valid;
    end

    task automatic issue8(input logic sb, input logic [31:0] x, input logic [31:0] y, input logic ci,
                          input logic [31:0] es, input logic eco, input logic eov);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!b8.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!b8.in_ready) begin
            bound_fail("k8_accept");
            return;
        end
        b8.in_valid = 1'b1;
        b8.sub      = sb;
        b8.X        = x;
        b8.Y        = y;
        b8.carryin  = ci;
        e.s = es; e.co = eco; e.ov = eov; e.acc = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        // Operands are scrambled after the accept edge; the result must not depend on them.
        b8.in_valid = 1'b0;
        b8.X        = $urandom;
        b8.Y        = $urandom;
        b8.sub      = 1'($urandom_range(0, 1));
        b8.carryin  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle8();
        int t;
        t = 0;
        while ((busy8 || b8.out_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy8 || b8.out_valid) bound_fail("k8_idle");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic [31:0] x, y;
        logic        sb, ci;
        longint      rs;
        longint unsigned ux, uy;
        exp_t        e;

        resetn = 1'b0;
        b8.in_valid = 0;  b8.sub = 0;  b8.X = 0;  b8.Y = 0;  b8.carryin = 0;  b8.out_ready = 1;
        b32.in_valid = 0; b32.sub = 0; b32.X = 0; b32.Y = 0; b32.carryin = 0; b32.out_ready = 1;
        b4.in_valid = 0;  b4.sub = 0;  b4.X = 0;  b4.Y = 0;  b4.carryin = 0;  b4.out_ready = 1;

        // Reset state, with a handshake attempt that must be ignored.
        @(negedge clk);
        b8.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_S", b8.S, 32'h0);
        check("rst_carryout", {31'd0, b8.carryout}, 32'd0);
        check("rst_overflow", {31'd0, b8.overflow}, 32'd0);
        check("rst_out_valid", {31'd0, b8.out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_in_ready", {31'd0, b8.in_ready}, 32'd1);
        b8.in_valid = 1'b0;
        resetn = 1'b1;

        // Carry across three chunk boundaries.
        issue8(0, 32'h00FF_FFFF, 32'h0000_0001, 0, 32'h0100_0000, 0, 0);
        wait_idle8();
        // Full wrap with carry-out, then positive overflow.
        issue8(0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 0);
        wait_idle8();
        issue8(0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0, 1);
        wait_idle8();
        check("hold_S_idle", b8.S, 32'h8000_0000);
        check("hold_ov_idle", {31'd0, b8.overflow}, 32'd1);
        // Carry-in on add.
        issue8(0, 32'h1234_5678, 32'h1111_1111, 1, 32'h2345_678A, 0, 0);
        wait_idle8();
        // Subtract with borrow, then negative overflow.
        issue8(1, 32'h0000_0005, 32'h0000_0007, 0, 32'hFFFF_FFFE, 0, 0);
        wait_idle8();
        issue8(1, 32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 1, 1);
        wait_idle8();
        // Borrow-in on subtract: 10 - 3 - 1.
        issue8(1, 32'h0000_000A, 32'h0000_0003, 1, 32'h0000_0006, 1, 0);
        wait_idle8();

        // Backpressure: result held for 10 cycles, new operands refused.
        b8.out_ready = 1'b0;
        issue8(0, 32'h1111_1111, 32'h2222_2222, 0, 32'h3333_3333, 0, 0);
        t = 0;
        while (!b8.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!b8.out_valid) bound_fail("bp_out_valid");
        for (int i = 0; i < 10; i++) begin
            check("bp_S", b8.S, 32'h3333_3333);
            check("bp_carryout", {31'd0, b8.carryout}, 32'd0);
            check("bp_overflow", {31'd0, b8.overflow}, 32'd0);
            check("bp_in_ready", {31'd0, b8.in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, b8.out_valid}, 32'd1);
            b8.in_valid = (i % 2 == 0);
            b8.X = 32'hDEAD_BEEF;
            b8.Y = 32'h0BAD_F00D;
            @(negedge clk);
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", {31'd0, b8.in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, b8.out_valid}, 32'd0);
        issue8(0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1, 32'h0000_0000, 1, 0);
        wait_idle8();

        // Reset mid-RUN after two chunk cycles: everything cleared at once.
        issue8(0, 32'h00FF_FFFF, 32'h0000_0001, 0, 32'h0100_0000, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("midrun_busy_before", {31'd0, busy8}, 32'd1);
        resetn = 1'b0;
        q8.delete();
        #1;
        check("midrun_S", b8.S, 32'h0);
        check("midrun_carryout", {31'd0, b8.carryout}, 32'd0);
        check("midrun_overflow", {31'd0, b8.overflow}, 32'd0);
        check("midrun_out_valid", {31'd0, b8.out_valid}, 32'd0);
        check("midrun_busy", {31'd0, busy8}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        issue8(0, 32'h00FF_FFFF, 32'h0000_0001, 0, 32'h0100_0000, 0, 0);
        wait_idle8();

        // Width sweep: K=32 and K=4 against an arithmetic reference.
        for (int n = 0; n < 1000; n++) begin
            x  = $urandom;
            y  = $urandom;
            sb = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            if (n == 0) begin x = 32'hFFFF_FFFF; y = 32'h0000_0001; sb = 0; ci = 0; end
            if (n == 1) begin x = 32'h8000_0000; y = 32'h0000_0001; sb = 1; ci = 0; end
            ux = 64'(x);
            uy = 64'(y);
            if (sb) begin
                rs   = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
                e.co = (ux >= uy + 64'(ci));
            end else begin
                rs   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
                e.co = (((ux + uy + 64'(ci)) >> 32) != 0);
            end
            e.s  = rs[31:0];
            e.ov = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
            @(negedge clk);
            b32.in_valid = 1; b32.sub = sb; b32.X = x; b32.Y = y; b32.carryin = ci;
            b4.in_valid  = 1; b4.sub  = sb; b4.X  = x; b4.Y  = y; b4.carryin  = ci;
            e.acc = cyc + 1;
            q32.push_back(e);
            q4.push_back(e);
            @(negedge clk);
            b32.in_valid = 0; b32.X = ~x;
            b4.in_valid  = 0; b4.X  = ~x;
            t = 0;
            while ((busy32 || busy4 || b32.out_valid || b4.out_valid) && t < 60) begin
                @(negedge clk);
                t++;
            end
            if (busy32 || busy4 || b32.out_valid || b4.out_valid) begin
                bound_fail("sweep_idle");
                break;
            end
        end

        repeat (20) @(negedge clk);
        check("q8_drained", q8.size(), 32'd0);
        check("q32_drained", q32.size(), 32'd0);
        check("q4_drained", q4.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
